except_ctrl: RTL and testbench

- Exception/interrupt scheduler between the MEM stage and the CP0 register file.
- Gathers per-instruction exception flags and the interrupt-pending state, then picks one winner by fixed priority.
- Drives the CP0 excepttype/EPC/BadVAddr inputs and sequences the pipeline flush and PC redirect.
- Holds an exception detected during a long stall until the stall releases.

---
 rtl/except_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_except_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/except_ctrl.sv
// except_ctrl: picks one exception/interrupt per MEM-stage instruction by fixed
// priority, drives the CP0 excepttype/EPC/BadVAddr inputs, and sequences the
// pipeline flush plus PC redirect. An exception seen during a global stall is
// latched and issued on the first unstalled cycle.
//
// Optional build macro: EXCEPT_CTRL_INT_SYNC_EN
//   defined   : hw_int goes through a 2-flop synchronizer before int_o
//   undefined : int_o follows hw_int combinationally
//
// Ports:
//   clk, rst (async, active-low)
//   longest_stall          global pipeline freeze
//   mem_*                  MEM-stage instruction info (valid, pc, delayslot, data addr)
//   exc_*                  per-instruction exception flags
//   hw_int                 external interrupt lines
//   cp0_status/cause/epc   CP0 state
//   int_o                  interrupt lines to CP0
//   excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o  to CP0
//   flush_o, new_pc_o      pipeline flush and redirect target
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        longest_stall,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delayslot,
    input  logic [31:0] mem_addr,
    input  logic        exc_adel_if,
    input  logic        exc_ri,
    input  logic        exc_ov,
    input  logic        exc_trap,
    input  logic        exc_sys,
    input  logic        exc_bp,
    input  logic        exc_adel_ld,
    input  logic        exc_ades,
    input  logic        exc_eret,
    input  logic [5:0]  hw_int,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  int_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam int unsigned      CNT_W       = 4;
    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic             MULTI_FLUSH = (FLUSH_CYCLES > 1);

    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TRAP = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_after_issue;
    logic [31:0]       r_code;
    logic [31:0]       r_pc;
    logic              r_ds;
    logic [31:0]       r_bad;
    logic [31:0]       r_new_pc;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_int_pending;
    logic [31:0]       w_code;
    logic [31:0]       w_bad;
    logic              w_has;
    logic [31:0]       w_new_pc;
    logic              w_issue;
    logic              w_unused;

    // Only the IE/EXL/IM/IP fields of Status and Cause matter here
    assign w_unused = &{1'b0, cp0_status[31:16], cp0_status[7:2],
                        cp0_cause[31:16], cp0_cause[7:0]};

    assign w_int_pending = cp0_status[0] & ~cp0_status[1] & mem_valid &
                           (|(cp0_cause[15:8] & cp0_status[15:8]));

    // Fixed-priority winner select; non-interrupt flags need a real instruction
    always_comb begin
        w_code = '0;
        w_bad  = '0;
        if (w_int_pending) begin
            w_code = EXC_INT;
        end else if (mem_valid) begin
            if (exc_adel_if) begin
                w_code = EXC_ADEL;
                w_bad  = mem_pc;
            end else if (exc_ri) begin
                w_code = EXC_RI;
            end else if (exc_ov) begin
                w_code = EXC_OV;
            end else if (exc_trap) begin
                w_code = EXC_TRAP;
            end else if (exc_sys) begin
                w_code = EXC_SYS;
            end else if (exc_bp) begin
                w_code = EXC_BP;
            end else if (exc_adel_ld) begin
                w_code = EXC_ADEL;
                w_bad  = mem_addr;
            end else if (exc_ades) begin
                w_code = EXC_ADES;
                w_bad  = mem_addr;
            end else if (exc_eret) begin
                w_code = EXC_ERET;
            end
        end
    end

    assign w_has         = (w_code != '0);
    assign w_new_pc      = (w_code == EXC_ERET) ? cp0_epc : EXC_VECTOR;
    assign w_after_issue = MULTI_FLUSH ? S_FLUSH : S_IDLE;
    assign w_issue       = ~longest_stall &
                           (((r_state == S_IDLE) & w_has) | (r_state == S_PEND));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_has) begin
                    w_state_nxt = longest_stall ? S_PEND : w_after_issue;
                end
            end
            S_PEND: begin
                if (!longest_stall) begin
                    w_state_nxt = w_after_issue;
                end
            end
            S_FLUSH: begin
                if (r_cnt == FLUSH_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the winner in IDLE (used by PEND replay and FLUSH new_pc);
    // counter tracks flush cycles already driven, the issue cycle being the first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code   <= '0;
            r_pc     <= '0;
            r_ds     <= 1'b0;
            r_bad    <= '0;
            r_new_pc <= '0;
            r_cnt    <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_has) begin
                r_code   <= w_code;
                r_pc     <= mem_pc;
                r_ds     <= mem_in_delayslot;
                r_bad    <= w_bad;
                r_new_pc <= w_new_pc;
            end
            if (w_issue) begin
                r_cnt <= CNT_W'(1);
            end else if (r_state == S_FLUSH) begin
                r_cnt <= (r_cnt == FLUSH_LAST) ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    // Output logic; everything forced to zero while reset is asserted
    always_comb begin
        excepttype_o        = '0;
        current_inst_addr_o = '0;
        is_in_delayslot_o   = 1'b0;
        bad_addr_o          = '0;
        flush_o             = 1'b0;
        new_pc_o            = '0;
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_has && !longest_stall) begin
                        excepttype_o        = w_code;
                        current_inst_addr_o = mem_pc;
                        is_in_delayslot_o   = mem_in_delayslot;
                        bad_addr_o          = w_bad;
                        flush_o             = 1'b1;
                        new_pc_o            = w_new_pc;
                    end
                end
                S_PEND: begin
                    if (!longest_stall) begin
                        excepttype_o        = r_code;
                        current_inst_addr_o = r_pc;
                        is_in_delayslot_o   = r_ds;
                        bad_addr_o          = r_bad;
                        flush_o             = 1'b1;
                        new_pc_o            = r_new_pc;
                    end
                end
                S_FLUSH: begin
                    flush_o  = 1'b1;
                    new_pc_o = r_new_pc;
                end
                default: ;
            endcase
        end
    end

`ifdef EXCEPT_CTRL_INT_SYNC_EN
    logic [5:0] r_int_s1;
    logic [5:0] r_int_s2;

    // Two-flop synchronizer for asynchronous interrupt lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_int_s1 <= '0;
            r_int_s2 <= '0;
        end else begin
            r_int_s1 <= hw_int;
            r_int_s2 <= r_int_s1;
        end
    end

    assign int_o = r_int_s2;
`else
    assign int_o = rst ? hw_int : '0;
`endif

endmodule

// File: tb/tb_except_ctrl.sv
module tb_except_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam logic [3:0]  CODES [10] = '{4'h1, 4'h4, 4'ha, 4'hc, 4'hd,
                                           4'h8, 4'h9, 4'h4, 4'h5, 4'he};
    // BadVAddr source per priority slot: 0 none, 1 mem_pc, 2 mem_addr
    localparam int          BSRC  [10] = '{0, 1, 0, 0, 0, 0, 0, 2, 2, 0};
    localparam int          FC    [2]  = '{1, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        longest_stall = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_pc = '0;
    logic        mem_in_delayslot = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        exc_adel_if = 1'b0, exc_ri = 1'b0, exc_ov = 1'b0, exc_trap = 1'b0;
    logic        exc_sys = 1'b0, exc_bp = 1'b0, exc_adel_ld = 1'b0, exc_ades = 1'b0;
    logic        exc_eret = 1'b0;
    logic [5:0]  hw_int = '0;
    logic [31:0] cp0_status = '0, cp0_cause = '0, cp0_epc = '0;

    logic [5:0]  int0, int1;
    logic [31:0] et0, pc0, bad0, npc0, et1, pc1, bad1, npc1;
    logic        ds0, fl0, ds1, fl1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(1)) u_d0 (
        .clk(clk), .rst(rst), .longest_stall(longest_stall), .mem_valid(mem_valid),
        .mem_pc(mem_pc), .mem_in_delayslot(mem_in_delayslot), .mem_addr(mem_addr),
        .exc_adel_if(exc_adel_if), .exc_ri(exc_ri), .exc_ov(exc_ov), .exc_trap(exc_trap),
        .exc_sys(exc_sys), .exc_bp(exc_bp), .exc_adel_ld(exc_adel_ld), .exc_ades(exc_ades),
        .exc_eret(exc_eret), .hw_int(hw_int), .cp0_status(cp0_status),
        .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .int_o(int0), .excepttype_o(et0),
        .current_inst_addr_o(pc0), .is_in_delayslot_o(ds0), .bad_addr_o(bad0),
        .flush_o(fl0), .new_pc_o(npc0));

    except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(3)) u_d1 (
        .clk(clk), .rst(rst), .longest_stall(longest_stall), .mem_valid(mem_valid),
        .mem_pc(mem_pc), .mem_in_delayslot(mem_in_delayslot), .mem_addr(mem_addr),
        .exc_adel_if(exc_adel_if), .exc_ri(exc_ri), .exc_ov(exc_ov), .exc_trap(exc_trap),
        .exc_sys(exc_sys), .exc_bp(exc_bp), .exc_adel_ld(exc_adel_ld), .exc_ades(exc_ades),
        .exc_eret(exc_eret), .hw_int(hw_int), .cp0_status(cp0_status),
        .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .int_o(int1), .excepttype_o(et1),
        .current_inst_addr_o(pc1), .is_in_delayslot_o(ds1), .bad_addr_o(bad1),
        .flush_o(fl1), .new_pc_o(npc1));

    typedef struct packed {
        logic        has;
        logic [31:0] code;
        logic [31:0] pc;
        logic [31:0] bad;
        logic [31:0] npc;
        logic        ds;
    } ev_t;

    typedef struct packed {
        logic [31:0] et;
        logic [31:0] pc;
        logic [31:0] bad;
        logic [31:0] npc;
        logic        ds;
        logic        fl;
    } out_t;

    // Reference model: pending event, remaining flush cycles, redirect target
    int          m_fl  [2] = '{0, 0};
    logic        m_pv  [2] = '{1'b0, 1'b0};
    ev_t         m_pe  [2] = '{'0, '0};
    logic [31:0] m_npc [2] = '{'0, '0};
    logic [5:0]  m_h1 = '0, m_h2 = '0;

    function automatic ev_t pick();
        ev_t        e;
        logic [9:0] f;
        e = '0;
        f[0]   = cp0_status[0] && !cp0_status[1] && mem_valid &&
                 ((cp0_cause[15:8] & cp0_status[15:8]) != 8'h0);
        f[9:1] = {exc_eret, exc_ades, exc_adel_ld, exc_bp, exc_sys, exc_trap,
                  exc_ov, exc_ri, exc_adel_if} & {9{mem_valid}};
        for (int i = 0; i < 10; i++) begin
            if (f[i] && !e.has) begin
                e.has  = 1'b1;
                e.code = 32'(CODES[i]);
                e.pc   = mem_pc;
                e.ds   = mem_in_delayslot;
                e.bad  = (BSRC[i] == 1) ? mem_pc : (BSRC[i] == 2) ? mem_addr : 32'h0;
                e.npc  = (CODES[i] == 4'he) ? cp0_epc : VEC;
            end
        end
        return e;
    endfunction

    function automatic out_t issue(ev_t e);
        out_t o;
        o.et = e.code; o.pc = e.pc; o.bad = e.bad; o.npc = e.npc; o.ds = e.ds; o.fl = 1'b1;
        return o;
    endfunction

    function automatic out_t expect_out(int k);
        out_t o;
        ev_t  w;
        o = '0;
        w = pick();
        if (!rst) return o;
        if (m_fl[k] != 0) begin
            o.fl  = 1'b1;
            o.npc = m_npc[k];
        end else if (m_pv[k]) begin
            if (!longest_stall) o = issue(m_pe[k]);
        end else if (w.has && !longest_stall) begin
            o = issue(w);
        end
        return o;
    endfunction

    function automatic logic [5:0] expect_int();
`ifdef EXCEPT_CTRL_INT_SYNC_EN
        return m_h2;
`else
        return rst ? hw_int : 6'h0;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        ev_t w;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_fl[k] <= 0; m_pv[k] <= 1'b0; m_pe[k] <= '0; m_npc[k] <= '0;
            end
            m_h1 <= '0;
            m_h2 <= '0;
        end else begin
            w = pick();
            m_h1 <= hw_int;
            m_h2 <= m_h1;
            for (int k = 0; k < 2; k++) begin
                if (m_fl[k] != 0) begin
                    m_fl[k] <= m_fl[k] - 1;
                end else if (m_pv[k]) begin
                    if (!longest_stall) begin
                        m_pv[k]  <= 1'b0;
                        m_fl[k]  <= FC[k] - 1;
                        m_npc[k] <= m_pe[k].npc;
                    end
                end else if (w.has) begin
                    if (longest_stall) begin
                        m_pv[k] <= 1'b1;
                        m_pe[k] <= w;
                    end else begin
                        m_fl[k]  <= FC[k] - 1;
                        m_npc[k] <= w.npc;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        out_t e0, e1;
        e0 = expect_out(0);
        e1 = expect_out(1);
        chk("d0_excepttype", et0, e0.et);
        chk("d0_inst_addr", pc0, e0.pc);
        chk("d0_delayslot", 32'(ds0), 32'(e0.ds));
        chk("d0_bad_addr", bad0, e0.bad);
        chk("d0_flush", 32'(fl0), 32'(e0.fl));
        chk("d0_new_pc", npc0, e0.npc);
        chk("d0_int", 32'(int0), 32'(expect_int()));
        chk("d1_excepttype", et1, e1.et);
        chk("d1_inst_addr", pc1, e1.pc);
        chk("d1_delayslot", 32'(ds1), 32'(e1.ds));
        chk("d1_bad_addr", bad1, e1.bad);
        chk("d1_flush", 32'(fl1), 32'(e1.fl));
        chk("d1_new_pc", npc1, e1.npc);
        chk("d1_int", 32'(int1), 32'(expect_int()));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        longest_stall = 1'b0; mem_valid = 1'b0; mem_in_delayslot = 1'b0;
        exc_adel_if = 1'b0; exc_ri = 1'b0; exc_ov = 1'b0; exc_trap = 1'b0;
        exc_sys = 1'b0; exc_bp = 1'b0; exc_adel_ld = 1'b0; exc_ades = 1'b0;
        exc_eret = 1'b0; cp0_status = '0; cp0_cause = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            clear_in();
        end
    endtask

    int stall_left = 0;

    initial begin
        // Reset state
        #2;
        chk("rst_flush", 32'(fl0), 32'h0);
        chk("rst_int", 32'(int1), 32'h0);
        idle(2);
        rst = 1'b1;
        idle(2);

        // 1: overflow, single-cycle flush
        tick(); mem_valid = 1'b1; exc_ov = 1'b1; mem_pc = 32'hBFC00100; #2;
        chk("t1_type", et0, 32'hc);
        chk("t1_pc", pc0, 32'hBFC00100);
        chk("t1_flush", 32'(fl0), 32'h1);
        chk("t1_newpc", npc0, 32'hBFC00380);
        tick(); clear_in(); #2;
        chk("t1_after_flush", 32'(fl0), 32'h0);
        chk("t1_after_type", et0, 32'h0);
        idle(4);

        // 2: priority ri over adel_ld, then adel_ld BadVAddr
        tick(); mem_valid = 1'b1; exc_ri = 1'b1; exc_adel_ld = 1'b1; mem_addr = 32'h80000003; #2;
        chk("t2_ri_type", et0, 32'ha);
        chk("t2_ri_bad", bad0, 32'h0);
        tick(); exc_ri = 1'b0; #2;
        chk("t2_ld_type", et0, 32'h4);
        chk("t2_ld_bad", bad0, 32'h80000003);
        idle(4);

        // 3: syscall held across a 5-cycle stall
        for (int i = 0; i < 5; i++) begin
            tick(); longest_stall = 1'b1; mem_valid = 1'b1; exc_sys = 1'b1; mem_pc = 32'h80001230; #2;
            chk("t3_stall_flush", 32'(fl0), 32'h0);
            chk("t3_stall_type", et0, 32'h0);
        end
        tick(); clear_in(); mem_pc = 32'h80009990; #2;
        chk("t3_type", et0, 32'h8);
        chk("t3_pc", pc0, 32'h80001230);
        chk("t3_flush", 32'(fl0), 32'h1);
        tick(); #2;
        chk("t3_one_cycle", 32'(fl0), 32'h0);
        idle(4);

        // 4: interrupt beats breakpoint; EXL masks it
        tick(); cp0_status = 32'h0000FF01; cp0_cause = 32'h00000400; mem_valid = 1'b1; exc_bp = 1'b1; #2;
        chk("t4_int", et0, 32'h1);
        tick(); cp0_status = 32'h0000FF03; #2;
        chk("t4_exl_bp", et0, 32'h9);
        idle(4);

        // 5: eret with 3-cycle flush, later overflow ignored
        tick(); mem_valid = 1'b1; exc_eret = 1'b1; cp0_epc = 32'hBFC00024; #2;
        chk("t5_type", et1, 32'he);
        chk("t5_newpc", npc1, 32'hBFC00024);
        chk("t5_flush", 32'(fl1), 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick(); exc_eret = 1'b0; exc_ov = 1'b1; #2;
            chk("t5_fl_type", et1, 32'h0);
            chk("t5_fl_flush", 32'(fl1), 32'h1);
            chk("t5_fl_newpc", npc1, 32'hBFC00024);
        end
        tick(); clear_in(); #2;
        chk("t5_done", 32'(fl1), 32'h0);
        idle(4);

        // 6: reset during FLUSH, then interrupt line pass-through
        tick(); mem_valid = 1'b1; exc_eret = 1'b1; #2;
        chk("t6_issue", 32'(fl1), 32'h1);
        tick(); clear_in(); #1; rst = 1'b0; #1;
        chk("t6_abort_flush", 32'(fl1), 32'h0);
        chk("t6_abort_newpc", npc1, 32'h0);
        hw_int = 6'h20;
        tick(); #2;
        chk("t6_rst_int", 32'(int0), 32'h0);
        tick(); rst = 1'b1; #2;
        chk("t6_idle", 32'(fl1), 32'h0);
`ifdef EXCEPT_CTRL_INT_SYNC_EN
        chk("t6_int_0clk", 32'(int0), 32'h0);
        tick(); #2;
        chk("t6_int_1clk", 32'(int0), 32'h0);
        tick(); #2;
        chk("t6_int_2clk", 32'(int0), 32'h20);
`else
        chk("t6_int_comb", 32'(int0), 32'h20);
`endif
        idle(3);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (stall_left > 0) begin
                stall_left--;
                longest_stall = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                stall_left = $urandom_range(1, 6);
                longest_stall = 1'b1;
            end else begin
                longest_stall = 1'b0;
            end
            mem_valid        = ($urandom_range(0, 3) != 0);
            mem_pc           = $urandom;
            mem_addr         = $urandom;
            mem_in_delayslot = $urandom_range(0, 1) == 1;
            exc_adel_if = ($urandom_range(0, 24) == 0);
            exc_ri      = ($urandom_range(0, 24) == 0);
            exc_ov      = ($urandom_range(0, 24) == 0);
            exc_trap    = ($urandom_range(0, 24) == 0);
            exc_sys     = ($urandom_range(0, 24) == 0);
            exc_bp      = ($urandom_range(0, 24) == 0);
            exc_adel_ld = ($urandom_range(0, 24) == 0);
            exc_ades    = ($urandom_range(0, 24) == 0);
            exc_eret    = ($urandom_range(0, 24) == 0);
            hw_int      = 6'($urandom);
            cp0_epc     = $urandom;
            case ($urandom_range(0, 3))
                0: cp0_status = 32'h0000FF01;
                1: cp0_status = 32'h0000FF03;
                2: cp0_status = $urandom;
                default: cp0_status = 32'h0;
            endcase
            cp0_cause = ($urandom_range(0, 5) == 0) ? ($urandom & 32'h0000FF00) : 32'h0;
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
